clock_period_meter: RTL and testbench
=====================================

# clock_period_meter

Measures an incoming slow clock or strobe, such as the divided display-scan and time-base clocks, in units of the system clock `clk`. For each input cycle it reports the period and the high time. It is the receiving end of the clock-divider path: the divider turns a count into a toggling signal, and this block turns a toggling signal back into a count. It is used for self-check of divider outputs and for measuring external pulse trains.

## Interface
- `CNT_W`, default 25: width of the counter and of the `period`/`high_time` outputs.
- `TIMEOUT`, default 33554431: cycle count after which a missing rising edge is declared. Must satisfy 2 ≤ `TIMEOUT` ≤ 2^`CNT_W` − 1.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-high. Clock is `clk`.
- `enable` in 1: measurement enable, level.
- `sig_in` in 1: signal under measurement. Asynchronous to `clk`.
- `period` out `CNT_W`: cycles from one rising edge to the next. Last valid value.
- `high_time` out `CNT_W`: cycles from a rising edge to the following falling edge, for the same input cycle as `period`.
- `valid` out 1: one-cycle pulse when `period`/`high_time` update.
- `timeout` out 1: level. High once no rising edge has arrived within `TIMEOUT` cycles.
- `measuring` out 1: high in state MEASURE.

## Operation
- Input conditioning:
  - 2-FF synchronizer `s1`→`s2`, then a history register `s3`.
  - `rise` = `s2` & ~`s3`.
  - `fall` = ~`s2` & `s3`.
- Free-running counter `cnt`, `CNT_W` bits:
  - On `rise`: `cnt` ← 1.
  - Otherwise in MEASURE: `cnt` ← `cnt` + 1, saturating at `TIMEOUT`.
  - In IDLE: `cnt` ← 0.
- State IDLE:
  - Waiting for the first rising edge. No outputs change.
  - `rise` & `enable` → MEASURE, with `cnt` ← 1.
- State MEASURE:
  - On `fall`: `hi_reg` ← `cnt`.
  - On `rise`: `period` ← `cnt`, `high_time` ← `hi_reg`, `valid` ← 1, `timeout` ← 0, `cnt` ← 1. Stay in MEASURE.
  - `cnt` == `TIMEOUT` with no `rise` this cycle → IDLE, `timeout` ← 1. `period`/`high_time` hold.
  - `enable` low → IDLE. The partial measurement is discarded, `timeout` is unchanged, and no `valid` is issued.
- `rise` and `cnt` == `TIMEOUT` in the same cycle: the rise wins. This is a normal measurement with `period` = `TIMEOUT`.
- If `fall` did not occur between two rises (not possible after synchronization), `high_time` takes the stale `hi_reg`. This needs no special handling.
- The first rise after entering MEASURE only starts the count. A `valid` needs two rises.
- Arithmetic is unsigned. `cnt` never wraps because of saturation at `TIMEOUT`.

## Timing
- Reset values:
  - `period` = 0, `high_time` = 0, `valid` = 0, `timeout` = 0, `measuring` = 0.
  - State IDLE, `cnt` = 0, `hi_reg` = 0, `s1`/`s2`/`s3` = 0.
- Reset asserted mid-measurement: all of the above take effect immediately, asynchronously. After release, the block restarts from IDLE.
- Latency:
  - `sig_in` rising, stable before a `clk` edge, to `rise` high: 2 cycles.
  - `valid` is registered, so it is high in the cycle after `rise`, 3 `clk` edges after the input edge.
  - The latency is constant, so it cancels in `period` and `high_time`.
- Resolution: ±1 cycle for asynchronous inputs; exact for inputs synchronous to `clk`.
- Minimum measurable input: high ≥ 2 cycles and low ≥ 2 cycles. Shorter pulses may be missed, which gives merged periods.
- `valid` is never high two cycles in a row. `period` and `high_time` change only in the cycle that `valid` is high.
- Timeout fires `TIMEOUT` cycles after the last `rise`. `timeout` rises in the cycle after `cnt` reaches `TIMEOUT`, and `measuring` drops in that same cycle.

## Test plan
- Divider-scan clock:
  - Stimulus: `sig_in` synchronous, toggling every 26 `clk` cycles, `enable` = 1.
  - Response: first `valid` after the second rise, then one `valid` every 52 cycles with `period` = 52 and `high_time` = 26.
- Time-base clock:
  - Stimulus: `sig_in` toggling every 10001 cycles.
  - Response: `period` = 20002, `high_time` = 10001, `timeout` = 0.
- Timeout:
  - Stimulus: `TIMEOUT` = 100, one rise, then `sig_in` held low.
  - Response: `timeout` = 1 and `measuring` = 0 exactly 101 cycles after `rise`, `period` unchanged. After the next two rises, 40 cycles apart: `valid`, `period` = 40, `timeout` = 0.
- Boundary:
  - Stimulus: `TIMEOUT` = 100, rises exactly 100 cycles apart.
  - Response: `valid` with `period` = 100, no timeout.
- Enable and reset mid-operation:
  - Stimulus: `enable` dropped 10 cycles after a rise, then re-asserted.
  - Response: no `valid`, and the next `valid` needs two fresh rises.
  - Stimulus: `reset` pulsed mid-period.
  - Response: all outputs 0 immediately.
- Asynchronous input:
  - Stimulus: `sig_in` with a 52.3-cycle period, random phase.
  - Response: every `period` is in {52, 53}, and `high_time` is within ±1 of 26.

Source files
------------

// File: rtl/clock_period_meter.sv
`timescale 1ns/1ps
// clock_period_meter
// Turns a slow toggling input (divided clock or external strobe) back into
// counts of clk: period from rising edge to rising edge, and high time from
// rising edge to the following falling edge.
// The input is asynchronous and is brought into the clk domain by two
// flops. This delay is the same for every edge, so it cancels out in both
// measured intervals.
module clock_period_meter #(
  parameter int          CNT_W   = 25,
  parameter int unsigned TIMEOUT = 33554431
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             measuring
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  logic             s1_q, s2_q, s3_q;
  logic             rise_s, fall_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             measuring_q, measuring_d;

  // Two-flop synchronizer plus a history flop used for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_s = s2_q & ~s3_q;
  assign fall_s = ~s2_q & s3_q;

  // Counter increment that holds at TIMEOUT so the count can never wrap.
  assign cnt_inc_s = (cnt_q == TIMEOUT_C) ? cnt_q : (cnt_q + ONE_C);

  // Next-state logic: edge handling, timeout detection and result capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (rise_s && enable) begin
          // This rise only opens the first measurement window.
          state_d = ST_MEASURE;
          cnt_d   = ONE_C;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = ZERO_C;
        end
      end
      ST_MEASURE: begin
        if (!enable) begin
          // Partial measurement is dropped; timeout keeps its value.
          state_d = ST_IDLE;
          cnt_d   = ZERO_C;
        end else if (rise_s) begin
          // A rise wins over a simultaneous timeout: period = TIMEOUT.
          period_d  = cnt_q;
          high_d    = hi_q;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          cnt_d     = ONE_C;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          cnt_d     = ZERO_C;
        end else begin
          cnt_d = cnt_inc_s;
          if (fall_s) begin
            hi_d = cnt_q;
          end else begin
            hi_d = hi_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = ZERO_C;
      end
    endcase
    measuring_d = (state_d == ST_MEASURE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= ZERO_C;
      hi_q        <= ZERO_C;
      period_q    <= ZERO_C;
      high_q      <= ZERO_C;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      measuring_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      measuring_q <= measuring_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign measuring = measuring_q;

endmodule

// File: tb/tb_clock_period_meter.sv
`timescale 1ns/1ps
// Directed bench for clock_period_meter. Two instances share the stimulus:
// a long one with default parameters and a short one with TIMEOUT = 100.
module tb_clock_period_meter;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic sig_in;

  logic [24:0] period_l, high_l;
  logic        valid_l, timeout_l, meas_l;
  logic [7:0]  period_s, high_s;
  logic        valid_s, timeout_s, meas_s;

  int errors = 0;
  int checks = 0;
  int vcnt_l = 0;
  int vcnt_s = 0;
  int snap_l, snap_s;
  int phase;

  logic        vprev_l = 1'b0, vprev_s = 1'b0;
  logic [24:0] pprev_l = 25'd0, hprev_l = 25'd0;
  logic [7:0]  pprev_s = 8'd0;
  logic        async_chk = 1'b0;

  always #5 clk = ~clk;

  clock_period_meter u_long (
    .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .period(period_l), .high_time(high_l), .valid(valid_l),
    .timeout(timeout_l), .measuring(meas_l)
  );

  clock_period_meter #(.CNT_W(8), .TIMEOUT(100)) u_short (
    .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .period(period_s), .high_time(high_s), .valid(valid_s),
    .timeout(timeout_s), .measuring(meas_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and apply the per-cycle invariants.
  task automatic tick();
    @(negedge clk);
    if (!reset) begin
      chk("valid_l_back2back", {31'd0, valid_l & vprev_l}, 32'd0);
      chk("valid_s_back2back", {31'd0, valid_s & vprev_s}, 32'd0);
      chk("period_l_hold", {31'd0, (period_l != pprev_l) && !valid_l}, 32'd0);
      chk("high_l_hold",   {31'd0, (high_l   != hprev_l) && !valid_l}, 32'd0);
      chk("period_s_hold", {31'd0, (period_s != pprev_s) && !valid_s}, 32'd0);
      if (valid_l) vcnt_l++;
      if (valid_s) vcnt_s++;
      if (async_chk && valid_l) begin
        chk("async_period_l", {31'd0, (period_l == 25'd52) || (period_l == 25'd53)}, 32'd1);
        chk("async_high_l", {31'd0, (high_l >= 25'd25) && (high_l <= 25'd27)}, 32'd1);
      end
      if (async_chk && valid_s) begin
        chk("async_period_s", {31'd0, (period_s == 8'd52) || (period_s == 8'd53)}, 32'd1);
      end
    end
    vprev_l = valid_l;
    vprev_s = valid_s;
    pprev_l = period_l;
    hprev_l = high_l;
    pprev_s = period_s;
  endtask

  task automatic hold(input logic lvl, input int n);
    sig_in = lvl;
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; sig_in = 1'b0;
    repeat (3) tick();
    chk("rst_period_l", period_l, 32'd0);
    chk("rst_high_l", high_l, 32'd0);
    chk("rst_valid_l", valid_l, 32'd0);
    chk("rst_timeout_l", timeout_l, 32'd0);
    chk("rst_meas_l", meas_l, 32'd0);
    chk("rst_period_s", period_s, 32'd0);
    chk("rst_meas_s", meas_s, 32'd0);
    reset = 1'b0; enable = 1'b1;
    hold(1'b0, 5);

    // Divider-scan clock: toggle every 26 cycles, four rises -> three results.
    for (int k = 0; k < 4; k++) begin
      hold(1'b1, 26);
      hold(1'b0, 26);
    end
    chk("div_vcnt_l", vcnt_l, 32'd3);
    chk("div_vcnt_s", vcnt_s, 32'd3);
    chk("div_period_l", period_l, 32'd52);
    chk("div_high_l", high_l, 32'd26);
    chk("div_period_s", period_s, 32'd52);
    chk("div_high_s", high_s, 32'd26);
    chk("div_meas_l", meas_l, 32'd1);

    // Exact latency: valid appears on the third edge after the input rise.
    sig_in = 1'b1;
    tick(); tick();
    chk("lat_n2_valid", valid_l, 32'd0);
    tick();
    chk("lat_n3_valid", valid_l, 32'd1);
    chk("lat_n3_period", period_l, 32'd52);
    tick();
    chk("lat_n4_valid", valid_l, 32'd0);
    hold(1'b1, 22);
    hold(1'b0, 26);

    // Time-base clock: toggle every 10001 cycles.
    hold(1'b1, 10001);
    hold(1'b0, 10001);
    sig_in = 1'b1;
    repeat (3) tick();
    chk("tb_valid_l", valid_l, 32'd1);
    chk("tb_period_l", period_l, 32'd20002);
    chk("tb_high_l", high_l, 32'd10001);
    chk("tb_timeout_l", timeout_l, 32'd0);
    chk("tb_timeout_s", timeout_s, 32'd1);
    chk("tb_period_s_held", period_s, 32'd52);
    chk("tb_meas_s_restart", meas_s, 32'd1);
    hold(1'b1, 20);
    hold(1'b0, 20);

    // Short instance: 43-cycle result clears timeout, then a real timeout.
    sig_in = 1'b1;
    repeat (3) tick();
    chk("b_valid_s", valid_s, 32'd1);
    chk("b_period_s", period_s, 32'd43);
    chk("b_high_s", high_s, 32'd23);
    chk("b_timeout_s", timeout_s, 32'd0);
    hold(1'b1, 17);
    hold(1'b0, 82);
    chk("to_n102_timeout", timeout_s, 32'd0);
    chk("to_n102_meas", meas_s, 32'd1);
    tick();
    chk("to_n103_timeout", timeout_s, 32'd1);
    chk("to_n103_meas", meas_s, 32'd0);
    chk("to_n103_period", period_s, 32'd43);
    hold(1'b0, 20);

    // Two rises 40 apart after the timeout.
    sig_in = 1'b1;
    repeat (3) tick();
    chk("c_valid_s", valid_s, 32'd0);
    chk("c_timeout_s", timeout_s, 32'd1);
    chk("c_meas_s", meas_s, 32'd1);
    hold(1'b1, 17);
    hold(1'b0, 20);
    sig_in = 1'b1;
    repeat (3) tick();
    chk("d_valid_s", valid_s, 32'd1);
    chk("d_period_s", period_s, 32'd40);
    chk("d_high_s", high_s, 32'd20);
    chk("d_timeout_s", timeout_s, 32'd0);

    // Boundary: rises exactly TIMEOUT cycles apart.
    hold(1'b1, 47);
    hold(1'b0, 50);
    sig_in = 1'b1;
    repeat (3) tick();
    chk("bnd_valid_s", valid_s, 32'd1);
    chk("bnd_period_s", period_s, 32'd100);
    chk("bnd_high_s", high_s, 32'd50);
    chk("bnd_timeout_s", timeout_s, 32'd0);
    chk("bnd_meas_s", meas_s, 32'd1);
    hold(1'b1, 47);
    hold(1'b0, 50);

    // Enable dropped 10 cycles after a rise, then restored.
    sig_in = 1'b1;
    repeat (3) tick();
    snap_l = vcnt_l;
    repeat (9) tick();
    enable = 1'b0;
    repeat (2) tick();
    chk("en_meas_l", meas_l, 32'd0);
    chk("en_timeout_s", timeout_s, 32'd0);
    repeat (8) tick();
    enable = 1'b1;
    hold(1'b1, 4);
    hold(1'b0, 26);
    sig_in = 1'b1;
    repeat (3) tick();
    chk("en_first_rise_vcnt", vcnt_l, snap_l);
    chk("en_first_rise_meas", meas_l, 32'd1);
    hold(1'b1, 23);
    hold(1'b0, 26);
    sig_in = 1'b1;
    repeat (3) tick();
    chk("en_second_valid", valid_l, 32'd1);
    chk("en_second_period", period_l, 32'd52);
    chk("en_second_high", high_l, 32'd26);
    chk("en_second_vcnt", vcnt_l, snap_l + 1);

    // Reset pulsed mid-period: outputs clear without waiting for a clock.
    repeat (10) tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_period_l", period_l, 32'd0);
    chk("arst_high_l", high_l, 32'd0);
    chk("arst_meas_l", meas_l, 32'd0);
    chk("arst_period_s", period_s, 32'd0);
    chk("arst_meas_s", meas_s, 32'd0);
    repeat (3) tick();
    sig_in = 1'b0;
    reset = 1'b0;
    hold(1'b0, 5);
    chk("post_rst_meas_l", meas_l, 32'd0);

    // Asynchronous input: 52.3-cycle period with random phase, ten rises.
    snap_l = vcnt_l;
    snap_s = vcnt_s;
    phase = $urandom_range(0, 9);
    async_chk = 1'b1;
    fork
      begin
        #(phase + 0.5);
        repeat (10) begin
          sig_in = 1'b1;
          #262;
          sig_in = 1'b0;
          #261;
        end
      end
      begin
        repeat (540) tick();
      end
    join
    async_chk = 1'b0;
    chk("async_vcnt_l", vcnt_l - snap_l, 32'd9);
    chk("async_vcnt_s", vcnt_s - snap_s, 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
